// File: rtl/uart_rx_pkt_parser.sv
// UART byte-stream packet parser: SOF, LEN, payload, CSUM into a held buffer.
// Define UART_PKT_TIMEOUT_EN to abort stalled frames after TIMEOUT_CLKS idle clocks.
module uart_rx_pkt_parser #(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int          TIMEOUT_CLKS = 5430,
  localparam int         AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_data_avail,
  input  logic [7:0]    i_databyte,
  output logic          o_pkt_valid,
  output logic [7:0]    o_pkt_len,
  input  logic          i_pkt_ack,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  output logic          o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t     state;
  logic [7:0] len;
  logic [7:0] sum;
  logic [7:0] idx;
  logic [7:0] mem [2**AW];
  logic       len_bad;
  logic       in_frame;
  logic       tmo_hit;

  assign len_bad  = (i_databyte == 8'd0) ||
                    ({1'b0, i_databyte} > 9'(MAX_LEN));
  assign in_frame = (state == S_LEN) || (state == S_DATA) ||
                    (state == S_CSUM);

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = in_frame && !i_data_avail &&
                   (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || i_data_avail || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CLKS == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      o_pkt_valid <= 1'b0;
      o_pkt_len   <= 8'd0;
      o_err       <= 1'b0;
      o_err_code  <= 2'b00;
      o_overrun   <= 1'b0;
      idx         <= 8'd0;
      len         <= 8'd0;
      sum         <= 8'd0;
    end else begin
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_data_avail && i_databyte == SOF_BYTE)
            state <= S_LEN;
        end
        S_LEN: begin
          if (i_data_avail) begin
            if (len_bad) begin
              o_err      <= 1'b1;
              o_err_code <= 2'b01;
              state      <= S_IDLE;
            end else begin
              len   <= i_databyte;
              sum   <= i_databyte;
              idx   <= 8'd0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (i_data_avail) begin
            sum <= sum + i_databyte;
            idx <= idx + 8'd1;
            if (idx == len - 8'd1)
              state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (i_data_avail) begin
            if (i_databyte == sum) begin
              o_pkt_valid <= 1'b1;
              o_pkt_len   <= len;
              state       <= S_HOLD;
            end else begin
              o_err      <= 1'b1;
              o_err_code <= 2'b10;
              state      <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          o_overrun <= i_data_avail;
          if (i_pkt_ack) begin
            o_pkt_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // stall abort wins over the (absent) byte of this cycle
      if (tmo_hit) begin
        o_err      <= 1'b1;
        o_err_code <= 2'b11;
        state      <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_DATA && i_data_avail)
      mem[idx[AW-1:0]] <= i_databyte;
  end

  always_ff @(posedge clk) begin
    if (rst)
      o_rd_data <= 8'd0;
    else
      o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Randomized bench for uart_rx_pkt_parser against a queue-based frame model.
// Honours UART_PKT_TIMEOUT_EN the same way the design does.
module tb_uart_rx_pkt_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 5430;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_data_avail = 1'b0;
  logic [7:0]    i_databyte = 8'd0;
  logic          i_pkt_ack = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          o_pkt_valid;
  logic [7:0]    o_pkt_len;
  logic [7:0]    o_rd_data;
  logic          o_err;
  logic [1:0]    o_err_code;
  logic          o_overrun;

  uart_rx_pkt_parser #(
    .MAX_LEN(MAX_LEN),
    .SOF_BYTE(8'hA5),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data_avail(i_data_avail),
    .i_databyte(i_databyte),
    .o_pkt_valid(o_pkt_valid),
    .o_pkt_len(o_pkt_len),
    .i_pkt_ack(i_pkt_ack),
    .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data),
    .o_err(o_err),
    .o_err_code(o_err_code),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame bytes collected so far, held packet flag
  logic [7:0] frame [$];
  bit         held;
  int         mlen;
  int         gap;
  logic [7:0] mbuf  [MAX_LEN];
  bit         known [MAX_LEN];
  bit         e_valid, e_err, e_ovr, e_rd_ok;
  logic [1:0] e_code;
  logic [7:0] e_len, e_rd;

  task automatic model_clear();
    frame.delete();
    held    = 1'b0;
    gap     = 0;
    e_valid = 1'b0;
    e_code  = 2'b00;
    e_len   = 8'd0;
    foreach (known[i]) known[i] = 1'b0;
  endtask

  task automatic model_step(bit av, logic [7:0] b, bit ack, int a);
    int n;
    int s;
    e_err   = 1'b0;
    e_ovr   = 1'b0;
    e_rd_ok = known[a];
    e_rd    = mbuf[a];
    if (held) begin
      if (av) e_ovr = 1'b1;
      if (ack) begin
        held    = 1'b0;
        e_valid = 1'b0;
      end
    end else if (av) begin
      gap = 0;
      n   = frame.size();
      if (n == 0) begin
        if (b == 8'hA5) frame.push_back(b);
      end else if (n == 1) begin
        if (b == 0 || int'(b) > MAX_LEN) begin
          e_err  = 1'b1;
          e_code = 2'b01;
          frame.delete();
        end else begin
          mlen = int'(b);
          frame.push_back(b);
        end
      end else if (n < mlen + 2) begin
        mbuf[n-2]  = b;
        known[n-2] = 1'b1;
        frame.push_back(b);
      end else begin
        s = 0;
        for (int i = 1; i < n; i++) s += int'(frame[i]);
        if (int'(b) == s % 256) begin
          held    = 1'b1;
          e_valid = 1'b1;
          e_len   = 8'(mlen);
        end else begin
          e_err  = 1'b1;
          e_code = 2'b10;
        end
        frame.delete();
      end
    end else if (frame.size() > 0) begin
      gap++;
`ifdef UART_PKT_TIMEOUT_EN
      if (gap >= TMO) begin
        e_err  = 1'b1;
        e_code = 2'b11;
        gap    = 0;
        frame.delete();
      end
`endif
    end
  endtask

  task automatic cycle(bit av, logic [7:0] b, bit ack, int a);
    @(negedge clk);
    i_data_avail = av;
    i_databyte   = b;
    i_pkt_ack    = ack;
    i_rd_addr    = AW'(a);
    model_step(av, b, ack, a);
    @(posedge clk);
    #1;
    check("valid", 32'(o_pkt_valid), 32'(e_valid));
    check("err", 32'(o_err), 32'(e_err));
    check("err_code", 32'(o_err_code), 32'(e_code));
    check("overrun", 32'(o_overrun), 32'(e_ovr));
    if (e_valid) check("pkt_len", 32'(o_pkt_len), 32'(e_len));
    if (e_rd_ok) check("rd_data", 32'(o_rd_data), 32'(e_rd));
  endtask

  function automatic int raddr();
    return $urandom_range(0, MAX_LEN - 1);
  endfunction

  task automatic tick();
    cycle(1'b0, 8'd0, 1'b0, raddr());
  endtask

  task automatic send(logic [7:0] q [$], int maxgap);
    foreach (q[i]) begin
      cycle(1'b1, q[i], 1'b0, raddr());
      repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    i_data_avail = 1'b0;
    i_pkt_ack    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(o_pkt_valid), 32'd0);
    check("rst_len", 32'(o_pkt_len), 32'd0);
    check("rst_rd", 32'(o_rd_data), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_code", 32'(o_err_code), 32'd0);
    check("rst_ovr", 32'(o_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [7:0] q [$];
    int         L;
    logic [7:0] s;
    model_clear();
    foreach (mbuf[i]) mbuf[i] = 8'd0;
    do_reset();

    // good frame, read back, ack
    q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send(q, 0);
    check("t1_valid", 32'(o_pkt_valid), 32'd1);
    check("t1_len", 32'(o_pkt_len), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 1'b0, i);
    cycle(1'b0, 8'd0, 1'b1, raddr());
    check("t1_ack", 32'(o_pkt_valid), 32'd0);

    // bad checksum, then a good frame
    q = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send(q, 1);
    q = {8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(q, 0);
    cycle(1'b0, 8'd0, 1'b1, 0);

    // bad lengths: zero and MAX_LEN+1
    q = {8'hA5, 8'h00};
    send(q, 0);
    q = {8'hA5, 8'(MAX_LEN + 1)};
    send(q, 0);
    q = {8'hA5, 8'h01, 8'h00, 8'h01};
    send(q, 0);
    cycle(1'b0, 8'd0, 1'b1, 0);

    // overruns while held, ack and byte together
    q = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
    send(q, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 8'hA4), 1'b0, i % 2);
    cycle(1'b1, 8'hA5, 1'b1, 1);
    check("t4_drop", 32'(o_pkt_valid), 32'd0);
    cycle(1'b0, 8'd0, 1'b1, raddr());

    // checksum wrap, then reset mid-frame
    q = {8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
    send(q, 0);
    cycle(1'b0, 8'd0, 1'b1, 0);
    q = {8'hA5, 8'h02};
    send(q, 0);
    do_reset();
    repeat (3) tick();

    // stalled frame
    q = {8'hA5, 8'h02, 8'h10};
    send(q, 0);
    repeat (TMO + 10) tick();
    do_reset();

    // randomized frames
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 7) == 0)
        cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, raddr());
      L = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(1, MAX_LEN);
      q = {8'hA5, 8'(L)};
      s = 8'(L);
      for (int i = 0; i < ((L <= MAX_LEN) ? L : 3); i++) begin
        q.push_back(8'($urandom_range(0, 255)));
        s = s + q[q.size() - 1];
      end
      q.push_back(($urandom_range(0, 4) == 0) ? (s ^ 8'h5A) : s);
      send(q, $urandom_range(0, 2));
      if (held) begin
        repeat ($urandom_range(0, 3))
          cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, raddr());
        repeat ($urandom_range(0, 4)) tick();
        cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'b1, raddr());
      end
      if ($urandom_range(0, 20) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
